// File: rtl/aes_sbox_scheduler.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// aes_sbox_scheduler
// Shares LANES external combinational S-box lanes between two requesters:
// the AES state (SubBytes on 128 bits) and the key expansion (SubWord on
// 32 bits). A job is latched on accept, pushed through the lanes LANES bytes
// per cycle, collected into a result register and returned on a valid/ready
// handshake.
//
// Configuration macro: SBOX_PIPE_EN
//   defined   : sbox_out is registered here before capture (+1 cycle latency)
//   undefined : sbox_out is captured combinationally in the beat that drives it
//
// Parameters:
//   LANES         S-box lanes per cycle (1, 2 or 4)
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   st_valid/st_ready/st_data             state job request (128-bit)
//   st_out_valid/st_out_ready/st_out_data SubBytes result
//   kw_valid/kw_ready/kw_data             key-word job request (32-bit)
//   kw_out_valid/kw_out_ready/kw_out_data SubWord result
//   sbox_in       lane j input  = sbox_in[8j+7:8j]
//   sbox_out      lane j result = sbox_out[8j+7:8j]
//   busy          high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module aes_sbox_scheduler #(
    parameter int LANES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 st_valid,
    output logic                 st_ready,
    input  logic [127:0]         st_data,
    output logic                 st_out_valid,
    input  logic                 st_out_ready,
    output logic [127:0]         st_out_data,
    input  logic                 kw_valid,
    output logic                 kw_ready,
    input  logic [31:0]          kw_data,
    output logic                 kw_out_valid,
    input  logic                 kw_out_ready,
    output logic [31:0]          kw_out_data,
    output logic [8*LANES-1:0]   sbox_in,
    input  logic [8*LANES-1:0]   sbox_out,
    output logic                 busy
);

    localparam int ST_BEATS = 16 / LANES;
    localparam int KW_BEATS = 4 / LANES;
`ifdef SBOX_PIPE_EN
    localparam int PIPE = 1;
`else
    localparam int PIPE = 0;
`endif
    localparam logic [4:0] ST_NB   = 5'(ST_BEATS);
    localparam logic [4:0] KW_NB   = 5'(KW_BEATS);
    // Counter value of the final RUN cycle (one extra cycle when pipelined)
    localparam logic [4:0] ST_LAST = 5'(ST_BEATS + PIPE - 1);
    localparam logic [4:0] KW_LAST = 5'(KW_BEATS + PIPE - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ST_RUN  = 3'd1,
        KW_RUN  = 3'd2,
        ST_DONE = 3'd3,
        KW_DONE = 3'd4
    } state_e;

    state_e                 state_q;
    logic [4:0]             cnt_q;
    logic                   last_kw_q;
    logic [127:0]           din_q;
    logic [127:0]           st_res_q;
    logic [31:0]            kw_res_q;
    logic                   st_ov_q;
    logic                   kw_ov_q;

    logic                   st_grant_s;
    logic                   kw_grant_s;
    logic                   run_s;
    logic                   issue_s;
    logic [4:0]             nb_s;
    logic [4:0]             last_cnt_s;
    logic [6:0]             issue_base_s;
    logic                   cap_en_s;
    logic [6:0]             cap_base_s;
    logic [8*LANES-1:0]     cap_data_s;

    // Arbitration: key word wins unless it won last time and state is waiting
    always_comb begin
        kw_grant_s = 1'b0;
        st_grant_s = 1'b0;
        if (state_q == IDLE) begin
            if (kw_valid && !(last_kw_q && st_valid)) begin
                kw_grant_s = 1'b1;
            end else if (st_valid) begin
                st_grant_s = 1'b1;
            end else begin
                kw_grant_s = 1'b0;
                st_grant_s = 1'b0;
            end
        end else begin
            kw_grant_s = 1'b0;
            st_grant_s = 1'b0;
        end
    end

    assign st_ready = st_grant_s;
    assign kw_ready = kw_grant_s;

    // Beat decode: which byte group of the latched input is on the lanes now
    always_comb begin
        run_s = (state_q == ST_RUN) || (state_q == KW_RUN);
        if (state_q == ST_RUN) begin
            nb_s       = ST_NB;
            last_cnt_s = ST_LAST;
        end else begin
            nb_s       = KW_NB;
            last_cnt_s = KW_LAST;
        end
        issue_s      = run_s && (cnt_q < nb_s);
        // Bit offset is a multiple of 8*LANES, so the slice always stays in range
        issue_base_s = 7'(32'(cnt_q) * (8 * LANES));
    end

    // Lane drive: zero outside an issuing beat
    always_comb begin
        if (issue_s) begin
            sbox_in = din_q[issue_base_s +: 8*LANES];
        end else begin
            sbox_in = '0;
        end
    end

`ifdef SBOX_PIPE_EN
    logic [8*LANES-1:0] pipe_q;

    // Pipeline register between the S-box bank and the result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= sbox_out;
        end
    end

    // Results land one cycle behind the beat that issued them
    assign cap_data_s = pipe_q;
    assign cap_en_s   = run_s && (cnt_q != 5'd0);
    assign cap_base_s = 7'(32'(cnt_q - 5'd1) * (8 * LANES));
`else
    assign cap_data_s = sbox_out;
    assign cap_en_s   = issue_s;
    assign cap_base_s = issue_base_s;
`endif

    // Main FSM, beat counter, latched job and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 5'd0;
            last_kw_q <= 1'b0;
            din_q     <= 128'd0;
            st_res_q  <= 128'd0;
            kw_res_q  <= 32'd0;
            st_ov_q   <= 1'b0;
            kw_ov_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (kw_grant_s) begin
                        din_q     <= {96'd0, kw_data};
                        cnt_q     <= 5'd0;
                        last_kw_q <= 1'b1;
                        state_q   <= KW_RUN;
                    end else if (st_grant_s) begin
                        din_q     <= st_data;
                        cnt_q     <= 5'd0;
                        last_kw_q <= 1'b0;
                        state_q   <= ST_RUN;
                    end
                end
                ST_RUN, KW_RUN: begin
                    cnt_q <= cnt_q + 5'd1;
                    if (cap_en_s) begin
                        if (state_q == ST_RUN) begin
                            st_res_q[cap_base_s +: 8*LANES] <= cap_data_s;
                        end else begin
                            kw_res_q[cap_base_s[4:0] +: 8*LANES] <= cap_data_s;
                        end
                    end
                    if (cnt_q == last_cnt_s) begin
                        if (state_q == ST_RUN) begin
                            state_q <= ST_DONE;
                            st_ov_q <= 1'b1;
                        end else begin
                            state_q <= KW_DONE;
                            kw_ov_q <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (st_out_ready) begin
                        st_ov_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                KW_DONE: begin
                    if (kw_out_ready) begin
                        kw_ov_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign st_out_valid = st_ov_q;
    assign st_out_data  = st_res_q;
    assign kw_out_valid = kw_ov_q;
    assign kw_out_data  = kw_res_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_aes_sbox_scheduler.sv
`timescale 1ns/1ps
// Bench for aes_sbox_scheduler: three instances (LANES = 4, 2, 1) with an
// S-box bank built from GF(2^8) arithmetic; a cycle-level reference model of
// the scheduler's handshake and timing checks every output on every cycle.
module tb_aes_sbox_scheduler;

`ifdef SBOX_PIPE_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         st_valid     [3];
    logic [127:0] st_data      [3];
    logic         st_out_ready [3];
    logic         kw_valid     [3];
    logic [31:0]  kw_data      [3];
    logic         kw_out_ready [3];

    wire          st_ready_w [3];
    wire          st_ov_w    [3];
    wire  [127:0] st_od_w    [3];
    wire          kw_ready_w [3];
    wire          kw_ov_w    [3];
    wire  [31:0]  kw_od_w    [3];
    wire          busy_w     [3];
    wire  [31:0]  sbi_w      [3];

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] ref_tbl [256];

    // ---------------- GF(2^8) S-box -----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_fn(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] bb;
        int e;
        r  = 8'h01;
        bb = x;
        e  = 254;
        while (e != 0) begin
            if ((e & 1) != 0) r = gmul(r, bb);
            bb = gmul(bb, bb);
            e  = e >> 1;
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic int lanes_of(input int k);
        return (k == 0) ? 4 : ((k == 1) ? 2 : 1);
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] x);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = ref_tbl[x[8*i +: 8]];
        return r;
    endfunction

    // ---------------- DUT instances -----------------
    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam int L = (k == 0) ? 4 : ((k == 1) ? 2 : 1);
        wire [8*L-1:0] sb_in;
        wire [8*L-1:0] sb_out;
        for (genvar j = 0; j < L; j++) begin : g_lane
            assign sb_out[8*j +: 8] = sbox_fn(sb_in[8*j +: 8]);
        end
        assign sbi_w[k] = 32'(sb_in);
        aes_sbox_scheduler #(.LANES(L)) u_dut (
            .clk          (clk),
            .rst          (rst),
            .st_valid     (st_valid[k]),
            .st_ready     (st_ready_w[k]),
            .st_data      (st_data[k]),
            .st_out_valid (st_ov_w[k]),
            .st_out_ready (st_out_ready[k]),
            .st_out_data  (st_od_w[k]),
            .kw_valid     (kw_valid[k]),
            .kw_ready     (kw_ready_w[k]),
            .kw_data      (kw_data[k]),
            .kw_out_valid (kw_ov_w[k]),
            .kw_out_ready (kw_out_ready[k]),
            .kw_out_data  (kw_od_w[k]),
            .sbox_in      (sb_in),
            .sbox_out     (sb_out),
            .busy         (busy_w[k])
        );
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model -----------------
    // phase 0 = idle, 1 = running (m_left cycles remain), 2 = result presented
    int           m_phase;
    bit           m_job_st;
    bit           m_last_kw;
    int           m_left;
    int           m_beats;
    logic [127:0] m_in;
    logic [127:0] m_exp;
    bit           obs_st;
    bit           obs_kw;

    task automatic model_cycle(input int k);
        int L;
        bit idle;
        bit e_kw;
        bit e_st;
        int bi;
        logic [127:0] sh;
        logic [31:0]  lmask;
        L     = lanes_of(k);
        lmask = (L == 4) ? 32'hFFFF_FFFF : ((L == 2) ? 32'h0000_FFFF : 32'h0000_00FF);
        idle  = (m_phase == 0);
        e_kw  = idle && kw_valid[k] && !(m_last_kw && st_valid[k]);
        e_st  = idle && st_valid[k] && !e_kw;
        obs_st = !rst && st_valid[k] && st_ready_w[k];
        obs_kw = !rst && kw_valid[k] && kw_ready_w[k];
        if (!rst) begin
            check_eq("kw_ready", kw_ready_w[k], e_kw);
            check_eq("st_ready", st_ready_w[k], e_st);
            check_eq("busy", busy_w[k], !idle);
            check_eq("st_out_valid", st_ov_w[k], (m_phase == 2) && m_job_st);
            check_eq("kw_out_valid", kw_ov_w[k], (m_phase == 2) && !m_job_st);
            if (m_phase == 2 && m_job_st)  check_eq("st_out_data", st_od_w[k], m_exp);
            if (m_phase == 2 && !m_job_st) check_eq("kw_out_data", kw_od_w[k], m_exp[31:0]);
            if (m_phase == 1) begin
                bi = m_beats + P - m_left;
                if (bi < m_beats) begin
                    sh = m_in >> (8 * L * bi);
                    check_eq("sbox_in_beat", sbi_w[k], sh[31:0] & lmask);
                end
            end else begin
                check_eq("sbox_in_idle", sbi_w[k], 32'd0);
            end
        end
        if (rst) begin
            m_phase   = 0;
            m_last_kw = 1'b0;
        end else begin
            case (m_phase)
                0: begin
                    if (e_kw) begin
                        m_job_st = 1'b0; m_last_kw = 1'b1;
                        m_in = {96'd0, kw_data[k]}; m_beats = 4 / L;
                        m_left = m_beats + P; m_exp = sub_bytes(m_in); m_phase = 1;
                    end else if (e_st) begin
                        m_job_st = 1'b1; m_last_kw = 1'b0;
                        m_in = st_data[k]; m_beats = 16 / L;
                        m_left = m_beats + P; m_exp = sub_bytes(m_in); m_phase = 1;
                    end
                end
                1: begin
                    m_left--;
                    if (m_left == 0) m_phase = 2;
                end
                2: begin
                    if ((m_job_st && st_out_ready[k]) || (!m_job_st && kw_out_ready[k])) m_phase = 0;
                end
                default: m_phase = 0;
            endcase
        end
    endtask

    // One clock: check/model at the falling edge, return just after the rising edge
    task automatic tick(input int k);
        @(negedge clk);
        model_cycle(k);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int k);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            st_valid[i] = 1'b0; kw_valid[i] = 1'b0;
            st_out_ready[i] = 1'b0; kw_out_ready[i] = 1'b0;
        end
        tick(k);
        tick(k);
        rst = 1'b0;
        m_phase = 0; m_last_kw = 1'b0; m_job_st = 1'b0;
    endtask

    // Single job with a free-running consumer; checks latency and result
    task automatic run_job(input int k, input bit is_st, input logic [127:0] d,
                           input int exp_lat, input logic [127:0] exp_d, input string tag);
        bit acc;
        bit seen;
        int lat;
        int w;
        st_out_ready[k] = 1'b1; kw_out_ready[k] = 1'b1;
        if (is_st) begin st_data[k] = d; st_valid[k] = 1'b1; end
        else begin kw_data[k] = d[31:0]; kw_valid[k] = 1'b1; end
        acc = 1'b0; w = 0;
        while (!acc && w < 20) begin
            tick(k);
            acc = is_st ? obs_st : obs_kw;
            w++;
        end
        st_valid[k] = 1'b0; kw_valid[k] = 1'b0;
        check_eq({tag, "_accept"}, acc, 1'b1);
        seen = 1'b0; lat = 0;
        while (acc && !seen && lat < 40) begin
            tick(k);
            lat++;
            if (is_st ? st_ov_w[k] : kw_ov_w[k]) begin
                seen = 1'b1;
                check_eq({tag, "_latency"}, lat, exp_lat);
                if (is_st) check_eq({tag, "_data"}, st_od_w[k], exp_d);
                else       check_eq({tag, "_data"}, kw_od_w[k], exp_d[31:0]);
            end
        end
        if (acc) check_eq({tag, "_valid_seen"}, seen, 1'b1);
        tick(k);
        tick(k);
    endtask

    initial begin
        int g [4];
        int ng;
        int w;
        logic [127:0] d;

        for (int i = 0; i < 256; i++) ref_tbl[i] = sbox_fn(8'(i));
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            st_valid[i] = 1'b0; kw_valid[i] = 1'b0;
            st_data[i] = 128'd0; kw_data[i] = 32'd0;
            st_out_ready[i] = 1'b0; kw_out_ready[i] = 1'b0;
        end
        do_reset(0);

        // Reset state of every instance
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check_eq("rst_st_ready", st_ready_w[k], 1'b0);
            check_eq("rst_kw_ready", kw_ready_w[k], 1'b0);
            check_eq("rst_st_out_valid", st_ov_w[k], 1'b0);
            check_eq("rst_kw_out_valid", kw_ov_w[k], 1'b0);
            check_eq("rst_st_out_data", st_od_w[k], 128'd0);
            check_eq("rst_kw_out_data", kw_od_w[k], 32'd0);
            check_eq("rst_busy", busy_w[k], 1'b0);
            check_eq("rst_sbox_in", sbi_w[k], 32'd0);
        end
        @(posedge clk); #1;

        // Known vectors and latency
        run_job(0, 1'b1, 128'd0, 4 + P, {16{8'h63}}, "zero_state_l4");
        run_job(2, 1'b0, 128'h00FF5301, 4 + P, 128'h6316ED7C, "kw_l1");
        do_reset(0);
        run_job(0, 1'b0, 128'h00FF5301, 1 + P, 128'h6316ED7C, "kw_l4");
        do_reset(1);
        run_job(1, 1'b1, 128'h000102030405060708090A0B0C0D0E0F, 8 + P,
                sub_bytes(128'h000102030405060708090A0B0C0D0E0F), "state_l2");

        // Simultaneous requests alternate KW, ST, KW, ST
        do_reset(0);
        st_out_ready[0] = 1'b1; kw_out_ready[0] = 1'b1;
        st_valid[0] = 1'b1; kw_valid[0] = 1'b1;
        st_data[0] = {$urandom, $urandom, $urandom, $urandom}; kw_data[0] = $urandom;
        ng = 0; w = 0;
        while (ng < 4 && w < 80) begin
            tick(0);
            w++;
            if (obs_kw) begin g[ng] = 1; ng++; kw_data[0] = $urandom; end
            if (obs_st) begin g[ng] = 0; ng++; st_data[0] = {$urandom, $urandom, $urandom, $urandom}; end
        end
        st_valid[0] = 1'b0; kw_valid[0] = 1'b0;
        check_eq("arb_grant_count", ng, 4);
        for (int i = 0; i < ng; i++) check_eq("arb_order", g[i], (i % 2 == 0) ? 1 : 0);
        for (int i = 0; i < 12; i++) tick(0);

        // Back-pressure: result held, nothing accepted, busy high
        do_reset(0);
        d = 128'h00112233445566778899AABBCCDDEEFF;
        st_data[0] = d; st_valid[0] = 1'b1;
        w = 0;
        while (!obs_st && w < 20) begin tick(0); w++; end
        check_eq("bp_accept", obs_st, 1'b1);
        st_valid[0] = 1'b1; kw_valid[0] = 1'b1; kw_data[0] = $urandom;
        w = 0;
        while (!st_ov_w[0] && w < 30) begin tick(0); w++; end
        check_eq("bp_valid_seen", st_ov_w[0], 1'b1);
        for (int i = 0; i < 10; i++) begin
            tick(0);
            check_eq("bp_st_out_valid", st_ov_w[0], 1'b1);
            check_eq("bp_st_out_data", st_od_w[0], sub_bytes(d));
            check_eq("bp_st_ready", st_ready_w[0], 1'b0);
            check_eq("bp_kw_ready", kw_ready_w[0], 1'b0);
            check_eq("bp_busy", busy_w[0], 1'b1);
        end
        st_out_ready[0] = 1'b1; kw_out_ready[0] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(0);
            if (obs_st) st_valid[0] = 1'b0;
            if (obs_kw) kw_valid[0] = 1'b0;
        end

        // Reset during beat 2 of a state job
        for (int k = 0; k < 3; k += 2) begin
            do_reset(k);
            st_out_ready[k] = 1'b1;
            st_data[k] = {$urandom, $urandom, $urandom, $urandom}; st_valid[k] = 1'b1;
            w = 0;
            while (!obs_st && w < 20) begin tick(k); w++; end
            check_eq("mid_rst_accept", obs_st, 1'b1);
            st_valid[k] = 1'b0;
            tick(k);
            tick(k);
            rst = 1'b1;
            tick(k);
            rst = 1'b0;
            check_eq("mid_rst_st_ready", st_ready_w[k], 1'b0);
            check_eq("mid_rst_kw_ready", kw_ready_w[k], 1'b0);
            check_eq("mid_rst_st_out_valid", st_ov_w[k], 1'b0);
            check_eq("mid_rst_kw_out_valid", kw_ov_w[k], 1'b0);
            check_eq("mid_rst_st_out_data", st_od_w[k], 128'd0);
            check_eq("mid_rst_kw_out_data", kw_od_w[k], 32'd0);
            check_eq("mid_rst_busy", busy_w[k], 1'b0);
            check_eq("mid_rst_sbox_in", sbi_w[k], 32'd0);
            for (int i = 0; i < 20; i++) begin
                tick(k);
                check_eq("mid_rst_no_pulse", st_ov_w[k], 1'b0);
            end
        end

        // Random traffic with back-pressure and occasional reset
        for (int k = 0; k < 3; k++) begin
            do_reset(k);
            for (int c = 0; c < 1500; c++) begin
                tick(k);
                if (obs_st) begin st_valid[k] = 1'b0; end
                if (obs_kw) begin kw_valid[k] = 1'b0; end
                if (!st_valid[k]) begin
                    st_data[k] = {$urandom, $urandom, $urandom, $urandom};
                    st_valid[k] = ($urandom_range(0, 99) < 40);
                end
                if (!kw_valid[k]) begin
                    kw_data[k] = $urandom;
                    kw_valid[k] = ($urandom_range(0, 99) < 40);
                end
                st_out_ready[k] = ($urandom_range(0, 99) < 50);
                kw_out_ready[k] = ($urandom_range(0, 99) < 50);
                rst = ($urandom_range(0, 199) == 0);
            end
            rst = 1'b0;
        end
        do_reset(0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
